// File: rtl/uart_cmd_if.sv
// Command-path bundle between uart_cmd_controller and its neighbours:
// UART receiver bytes, register-file strobes and transmitter handshake.
interface uart_cmd_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  rx_data_valid;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_par_error;
  logic                  rx_frame_error;
  logic [DATA_WIDTH-1:0] reg_rd_data;
  logic                  reg_rd_valid;
  logic                  tx_ready;
  logic                  reg_wr_en;
  logic                  reg_rd_en;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [DATA_WIDTH-1:0] reg_wr_data;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_data_valid;
  logic                  cmd_error;
  logic                  busy;

  // Controller side
  modport master (
    input  rx_data_valid, rx_data, rx_par_error, rx_frame_error,
    input  reg_rd_data, reg_rd_valid, tx_ready,
    output reg_wr_en, reg_rd_en, reg_addr, reg_wr_data,
    output tx_data, tx_data_valid, cmd_error, busy
  );

  // Receiver / register file / transmitter side
  modport slave (
    output rx_data_valid, rx_data, rx_par_error, rx_frame_error,
    output reg_rd_data, reg_rd_valid, tx_ready,
    input  reg_wr_en, reg_rd_en, reg_addr, reg_wr_data,
    input  tx_data, tx_data_valid, cmd_error, busy
  );
endinterface

// File: rtl/uart_cmd_controller.sv
// Turns UART receiver bytes into register write/read commands and returns
// read data to the transmitter; bad frames and stalled commands raise cmd_error.
module uart_cmd_controller #(
  parameter int unsigned           DATA_WIDTH     = 8,
  parameter int unsigned           ADDR_WIDTH     = 4,
  parameter int unsigned           TIMEOUT_CYCLES = 5000,
  parameter logic [DATA_WIDTH-1:0] WR_OPCODE      = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] RD_OPCODE      = 8'hBB
) (
  input  logic        clk,
  input  logic        reset_n,
  uart_cmd_if.master  bus
);

  localparam int unsigned    CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The error registers one edge after the counter would hit TIMEOUT_CYCLES-1
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] txd_q, txd_d;
  logic                  txv_q, txv_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;

  logic accept_c, bad_c, timer_on_c, timeout_c;

  assign accept_c   = bus.rx_data_valid & ~bus.rx_par_error & ~bus.rx_frame_error;
  assign bad_c      = bus.rx_data_valid & (bus.rx_par_error | bus.rx_frame_error);
  assign timer_on_c = (state_q == WR_ADDR) || (state_q == WR_DATA) ||
                      (state_q == RD_ADDR) || (state_q == RD_WAIT);
  assign timeout_c  = timer_on_c && (cnt_q == CNT_LAST);

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      txd_q   <= '0;
      txv_q   <= 1'b0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    txd_d   = txd_q;
    txv_d   = txv_q;
    wr_en_d = 1'b0;
    rd_en_d = 1'b0;
    err_d   = 1'b0;

    // A corrupt byte or a stall discards the whole command; one pulse either way
    if (bad_c || timeout_c) begin
      state_d = IDLE;
      cnt_d   = '0;
      txv_d   = 1'b0;
      err_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (accept_c) begin
            if (bus.rx_data == WR_OPCODE)      state_d = WR_ADDR;
            else if (bus.rx_data == RD_OPCODE) state_d = RD_ADDR;
            else                               err_d   = 1'b1;
          end
        end
        WR_ADDR: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (accept_c) begin
            addr_d  = bus.rx_data[ADDR_WIDTH-1:0];
            cnt_d   = '0;
            state_d = WR_DATA;
          end
        end
        WR_DATA: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (accept_c) begin
            wdata_d = bus.rx_data;
            wr_en_d = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        RD_ADDR: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (accept_c) begin
            addr_d  = bus.rx_data[ADDR_WIDTH-1:0];
            rd_en_d = 1'b1;
            cnt_d   = '0;
            state_d = RD_WAIT;
          end
        end
        RD_WAIT: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (accept_c) begin
            err_d = 1'b1;
            cnt_d = '0;
          end
          if (bus.reg_rd_valid) begin
            txd_d   = bus.reg_rd_data;
            txv_d   = 1'b1;
            cnt_d   = '0;
            state_d = TX_SEND;
          end
        end
        TX_SEND: begin
          cnt_d = '0;
          if (accept_c) err_d = 1'b1;
          if (bus.tx_ready) begin
            txv_d   = 1'b0;
            state_d = IDLE;
          end
        end
        default: begin
          cnt_d   = '0;
          txv_d   = 1'b0;
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign bus.reg_wr_en     = wr_en_q;
  assign bus.reg_rd_en     = rd_en_q;
  assign bus.reg_addr      = addr_q;
  assign bus.reg_wr_data   = wdata_q;
  assign bus.tx_data       = txd_q;
  assign bus.tx_data_valid = txv_q;
  assign bus.cmd_error     = err_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_uart_cmd_controller.sv
// Scoreboard bench for uart_cmd_controller: stimulus queues expected output
// events, a negedge monitor pops and compares every observed event.
module tb_uart_cmd_controller;

  localparam int K_WR  = 0;
  localparam int K_RD  = 1;
  localparam int K_TX  = 2;
  localparam int K_ERR = 3;

  typedef struct {
    int         src;
    int         kind;
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;   // 0 = any cycle
  } ev_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  ev_t  exp_q[$];

  uart_cmd_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus_m ();
  uart_cmd_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus_t ();

  // Main instance: timeout long enough for 20-cycle byte spacing
  uart_cmd_controller #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(32),
                        .WR_OPCODE(8'hAA), .RD_OPCODE(8'hBB))
    dut (.clk(clk), .reset_n(reset_n), .bus(bus_m));

  // Short-timeout instance used only for the stall case
  uart_cmd_controller #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(16),
                        .WR_OPCODE(8'hAA), .RD_OPCODE(8'hBB))
    dut_t (.clk(clk), .reset_n(reset_n), .bus(bus_t));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int src, input int kind, input logic [7:0] addr,
                      input logic [7:0] data, input int at_cyc);
    ev_t e;
    e.src = src; e.kind = kind; e.addr = addr; e.data = data; e.cyc = at_cyc;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int src, input int kind, input logic [7:0] addr,
                          input logic [7:0] data);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: src %0d kind %0d addr %0h data %0h cyc %0d",
               src, kind, addr, data, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.src != src || e.kind != kind || e.addr != addr || e.data != data ||
          (e.cyc != 0 && e.cyc != cyc)) begin
        n_bad++;
        $display("FAIL event: got src %0d kind %0d addr %0h data %0h cyc %0d, expected src %0d kind %0d addr %0h data %0h cyc %0d",
                 src, kind, addr, data, cyc, e.src, e.kind, e.addr, e.data, e.cyc);
      end
    end
  endtask

  // Monitor: every strobe, transfer and error pulse must match the queue head
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus_m.reg_wr_en) check_ev(0, K_WR, {4'h0, bus_m.reg_addr}, bus_m.reg_wr_data);
      if (bus_m.reg_rd_en) check_ev(0, K_RD, {4'h0, bus_m.reg_addr}, 8'h00);
      if (bus_m.tx_data_valid && bus_m.tx_ready) check_ev(0, K_TX, 8'h00, bus_m.tx_data);
      if (bus_m.cmd_error) check_ev(0, K_ERR, 8'h00, 8'h00);
      if (bus_t.reg_wr_en) check_ev(1, K_WR, {4'h0, bus_t.reg_addr}, bus_t.reg_wr_data);
      if (bus_t.reg_rd_en) check_ev(1, K_RD, {4'h0, bus_t.reg_addr}, 8'h00);
      if (bus_t.tx_data_valid && bus_t.tx_ready) check_ev(1, K_TX, 8'h00, bus_t.tx_data);
      if (bus_t.cmd_error) check_ev(1, K_ERR, 8'h00, 8'h00);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called one step after a rising edge; byte is sampled on the next edge
  task automatic send(input int src, input logic [7:0] b, input bit perr = 1'b0);
    if (src == 0) begin
      bus_m.rx_data = b; bus_m.rx_par_error = perr; bus_m.rx_data_valid = 1'b1;
    end else begin
      bus_t.rx_data = b; bus_t.rx_par_error = perr; bus_t.rx_data_valid = 1'b1;
    end
    step(1);
    bus_m.rx_data_valid = 1'b0; bus_m.rx_par_error = 1'b0;
    bus_t.rx_data_valid = 1'b0; bus_t.rx_par_error = 1'b0;
  endtask

  task automatic chk_zero(input string name);
    chk(name, {7'h0, bus_m.reg_wr_en, bus_m.reg_rd_en, bus_m.reg_addr, bus_m.reg_wr_data,
               bus_m.tx_data, bus_m.tx_data_valid, bus_m.cmd_error, bus_m.busy}, 32'h0);
  endtask

  task automatic wait_rd_en(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus_m.reg_rd_en) begin ok = 1'b1; break; end
      step(1);
    end
    chk(name, 32'(ok), 32'h1);
  endtask

  task automatic wait_tx_valid(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus_m.tx_data_valid) begin ok = 1'b1; break; end
      step(1);
    end
    chk(name, 32'(ok), 32'h1);
  endtask

  task automatic tx_accept();
    bus_m.tx_ready = 1'b1;
    step(1);
    bus_m.tx_ready = 1'b0;
  endtask

  initial begin
    int c0;
    bus_m.rx_data_valid = 1'b0; bus_m.rx_data = '0; bus_m.rx_par_error = 1'b0;
    bus_m.rx_frame_error = 1'b0; bus_m.reg_rd_data = '0; bus_m.reg_rd_valid = 1'b0;
    bus_m.tx_ready = 1'b0;
    bus_t.rx_data_valid = 1'b0; bus_t.rx_data = '0; bus_t.rx_par_error = 1'b0;
    bus_t.rx_frame_error = 1'b0; bus_t.reg_rd_data = '0; bus_t.reg_rd_valid = 1'b0;
    bus_t.tx_ready = 1'b0;

    step(3);
    chk_zero("reset_outputs");
    chk("reset_busy_t", 32'(bus_t.busy), 32'h0);
    reset_n = 1'b1;
    step(2);

    // Write: AA,05,3C with 20-cycle spacing
    send(0, 8'hAA); step(19);
    send(0, 8'h05);
    chk("wr_busy_mid", 32'(bus_m.busy), 32'h1);
    step(19);
    push(0, K_WR, 8'h05, 8'h3C, 0);
    send(0, 8'h3C);
    step(1);
    chk("wr_busy_after", 32'(bus_m.busy), 32'h0);
    step(3);

    // Read: BB,0A; read data 2 cycles after strobe; tx stalled 10 cycles
    send(0, 8'hBB);
    push(0, K_RD, 8'h0A, 8'h00, 0);
    send(0, 8'h0A);
    wait_rd_en("rd_en_seen");
    step(2);
    bus_m.reg_rd_data = 8'h5E; bus_m.reg_rd_valid = 1'b1;
    step(1);
    bus_m.reg_rd_valid = 1'b0;
    wait_tx_valid("tx_valid_seen");
    for (int i = 0; i < 10; i++) begin
      chk("tx_hold_valid", 32'(bus_m.tx_data_valid), 32'h1);
      chk("tx_hold_data", 32'(bus_m.tx_data), 32'h5E);
      step(1);
    end
    push(0, K_TX, 8'h00, 8'h5E, 0);
    tx_accept();
    chk("tx_valid_dropped", 32'(bus_m.tx_data_valid), 32'h0);
    chk("rd_busy_after", 32'(bus_m.busy), 32'h0);
    step(3);

    // Bad byte in WR_DATA discards the command; a clean retry writes
    send(0, 8'hAA);
    send(0, 8'h03);
    push(0, K_ERR, 8'h00, 8'h00, 0);
    send(0, 8'h77, 1'b1);
    chk("bad_busy", 32'(bus_m.busy), 32'h0);
    step(3);
    send(0, 8'hAA);
    send(0, 8'h03);
    push(0, K_WR, 8'h03, 8'h11, 0);
    send(0, 8'h11);
    step(3);

    // Timeout on the short instance: error 16 cycles after the opcode
    c0 = cyc;
    push(1, K_ERR, 8'h00, 8'h00, c0 + 16);
    send(1, 8'hAA);
    chk("to_busy_mid", 32'(bus_t.busy), 32'h1);
    step(20);
    chk("to_busy_after", 32'(bus_t.busy), 32'h0);

    // Unknown opcode
    push(0, K_ERR, 8'h00, 8'h00, 0);
    send(0, 8'h42);
    chk("unk_busy", 32'(bus_m.busy), 32'h0);
    step(3);

    // Read data in the same cycle as the strobe, then overrun in TX_SEND
    send(0, 8'hBB);
    push(0, K_RD, 8'h07, 8'h00, 0);
    send(0, 8'h07);
    wait_rd_en("rd_en_seen2");
    bus_m.reg_rd_data = 8'h99; bus_m.reg_rd_valid = 1'b1;
    step(1);
    bus_m.reg_rd_valid = 1'b0; bus_m.reg_rd_data = 8'h00;
    wait_tx_valid("tx_valid_seen2");
    push(0, K_ERR, 8'h00, 8'h00, 0);
    send(0, 8'h55);
    chk("ovr_tx_data", 32'(bus_m.tx_data), 32'h99);
    chk("ovr_tx_valid", 32'(bus_m.tx_data_valid), 32'h1);
    chk("ovr_busy", 32'(bus_m.busy), 32'h1);
    step(2);
    push(0, K_TX, 8'h00, 8'h99, 0);
    tx_accept();
    chk("ovr_valid_dropped", 32'(bus_m.tx_data_valid), 32'h0);
    step(3);

    // Asynchronous reset in WR_DATA; the late data byte is then an unknown opcode
    send(0, 8'hAA);
    send(0, 8'h05);
    step(3);
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("async_reset_outputs");
    step(1);
    reset_n = 1'b1;
    step(1);
    push(0, K_ERR, 8'h00, 8'h00, 0);
    send(0, 8'h3C);
    step(5);
    chk("post_reset_busy", 32'(bus_m.busy), 32'h0);

    step(5);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
